// File: rtl/sat_frame_checker_pkg.sv
// sat_frame_checker_pkg: shared constants, FSM encodings and CRC-8 step for the satellite frame checker
// Contents: SYNC_PATTERN, CRC8_POLY, 2-bit FSM state codes, frame field offsets, crc8_step()
package sat_frame_checker_pkg;
   localparam logic [7:0] SYNC_PATTERN = 8'hA5;
   localparam logic [7:0] CRC8_POLY    = 8'h07;
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_CAPTURE   = 2'd1;
   localparam logic [1:0] ST_CRC       = 2'd2;
   localparam logic [1:0] ST_RESULT    = 2'd3;
   localparam int CRC_LSB     = 0;
   localparam int PAYLOAD_LSB = 8;
   // One MSB-first shift of a non-reflected CRC-8.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
      return {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? CRC8_POLY : 8'h00);
   endfunction
endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR)
// Ports: clk, nReset (async active-low), clear (sync reload to 0), bitEn (consume bitIn), bitIn, crc[7:0]
// Compiled only when SAT_FRAME_CRC_EN is defined, since only that build instantiates it.
`ifdef SAT_FRAME_CRC_EN
module crc8_serial
   import sat_frame_checker_pkg::*;
(
   input  logic       clk,
   input  logic       nReset,
   input  logic       clear,
   input  logic       bitEn,
   input  logic       bitIn,
   output logic [7:0] crc
);
   always_ff @(posedge clk or negedge nReset)
      if (!nReset)
         crc <= '0;
      else if (clear)
         crc <= '0;
      else if (bitEn)
         crc <= crc8_step(crc, bitIn);
endmodule
`endif

// File: rtl/sat_frame_checker.sv
// sat_frame_checker: validates sync and CRC-8 of a captured satellite frame, qualifies the payload, keeps a link watchdog
// Optional feature macro: SAT_FRAME_CRC_EN (defined: serial CRC-8 check; undefined: sync check only, crcErr stays 0)
// Ports: masterClk, nReset (async active-low), enableShift (falling edge = frame end), frameData[FW-1:0],
//        payloadOut, payloadValid, syncErr, crcErr, overrunErr (1-cycle pulses), errCnt (saturating), wdTimeout (level)
module sat_frame_checker
   import sat_frame_checker_pkg::*;
#(
   parameter  int PAYLOAD_W = 8,
   parameter  int WD_TICKS  = 3000000,
   parameter  int ERRCNT_W  = 8,
   localparam int FW        = PAYLOAD_W + 16
) (
   input  logic                 masterClk,
   input  logic                 nReset,
   input  logic                 enableShift,
   input  logic [FW-1:0]        frameData,
   output logic [PAYLOAD_W-1:0] payloadOut,
   output logic                 payloadValid,
   output logic                 syncErr,
   output logic                 crcErr,
   output logic                 overrunErr,
   output logic [ERRCNT_W-1:0]  errCnt,
   output logic                 wdTimeout
);
   localparam int WD_W = $clog2(WD_TICKS);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_TICKS - 1);
   logic [1:0]           state, state_nx;
   logic                 prev_enable_shift, frame_end, sync_mis, sync_bad, crc_ok, overrun_pend;
   logic                 pv_nx, sync_nx, crc_nx;
   logic [1:0]           err_inc;
   logic [ERRCNT_W:0]    err_sum;
   logic [PAYLOAD_W-1:0] payload_reg;
   logic [WD_W-1:0]      wd_cnt;

   assign frame_end = prev_enable_shift & ~enableShift;
   assign sync_mis  = frameData[FW-1 -: 8] != SYNC_PATTERN;
   // A result pulse and an overrun pulse can land in the same cycle, so up to two events per cycle.
   assign err_inc   = 2'(sync_nx) + 2'(crc_nx) + 2'(overrun_pend);
   assign err_sum   = {1'b0, errCnt} + (ERRCNT_W + 1)'(err_inc);
   // Counter clears on the same edge that raises payloadValid, so the timeout drops with the pulse.
   assign wdTimeout = wd_cnt == WD_MAX;

`ifdef SAT_FRAME_CRC_EN
   localparam int MSG_W = PAYLOAD_W + 8;
   localparam int CNT_W = $clog2(MSG_W);
   logic [MSG_W-1:0] msg;
   logic [7:0]       fcs, crc;
   logic [CNT_W-1:0] bit_cnt;

   crc8_serial u_crc (
      .clk    (masterClk),
      .nReset (nReset),
      .clear  (state == ST_CAPTURE),
      .bitEn  (state == ST_CRC),
      .bitIn  (msg[MSG_W-1]),
      .crc    (crc)
   );

   assign crc_ok = crc == fcs;

   // Sync+payload is shifted out MSB first, one bit per CRC cycle.
   always_ff @(posedge masterClk or negedge nReset)
      if (!nReset) begin
         msg     <= '0;
         fcs     <= '0;
         bit_cnt <= '0;
      end else if (state == ST_CAPTURE) begin
         msg     <= frameData[FW-1:PAYLOAD_LSB];
         fcs     <= frameData[CRC_LSB +: 8];
         bit_cnt <= CNT_W'(MSG_W - 1);
      end else if (state == ST_CRC) begin
         msg     <= msg << 1;
         bit_cnt <= bit_cnt - 1'b1;
      end
`else
   logic unused_fcs;
   assign unused_fcs = ^frameData[CRC_LSB +: 8];
   assign crc_ok     = 1'b1;
`endif

   always_comb begin
      state_nx = state;
      pv_nx    = 1'b0;
      sync_nx  = 1'b0;
      crc_nx   = 1'b0;
      case (state)
         ST_IDLE:    state_nx = frame_end ? ST_CAPTURE : ST_IDLE;
`ifdef SAT_FRAME_CRC_EN
         ST_CAPTURE: state_nx = sync_mis ? ST_RESULT : ST_CRC;
         ST_CRC:     state_nx = bit_cnt == '0 ? ST_RESULT : ST_CRC;
`else
         ST_CAPTURE: state_nx = ST_RESULT;
`endif
         default: begin
            state_nx = ST_IDLE;
            sync_nx  = sync_bad;
            pv_nx    = ~sync_bad & crc_ok;
            crc_nx   = ~sync_bad & ~crc_ok;
         end
      endcase
   end

   always_ff @(posedge masterClk or negedge nReset)
      if (!nReset) begin
         state             <= ST_IDLE;
         prev_enable_shift <= 1'b0;
         sync_bad          <= 1'b0;
         payload_reg       <= '0;
         overrun_pend      <= 1'b0;
         overrunErr        <= 1'b0;
         payloadValid      <= 1'b0;
         syncErr           <= 1'b0;
         crcErr            <= 1'b0;
         payloadOut        <= '0;
         errCnt            <= '0;
         wd_cnt            <= '0;
      end else begin
         state             <= state_nx;
         prev_enable_shift <= enableShift;
         if (state == ST_CAPTURE) begin
            sync_bad    <= sync_mis;
            payload_reg <= frameData[PAYLOAD_LSB +: PAYLOAD_W];
         end
         // A frame end while busy is dropped; its pulse comes one cycle after detection.
         overrun_pend      <= frame_end & (state != ST_IDLE);
         overrunErr        <= overrun_pend;
         payloadValid      <= pv_nx;
         syncErr           <= sync_nx;
         crcErr            <= crc_nx;
         if (pv_nx)
            payloadOut <= payload_reg;
         errCnt            <= err_sum[ERRCNT_W] ? '1 : err_sum[ERRCNT_W-1:0];
         wd_cnt            <= pv_nx ? '0 : (wd_cnt == WD_MAX ? wd_cnt : wd_cnt + 1'b1);
      end
endmodule
